// File: rtl/core_pkg.sv
// Shared core definitions: funct3 load/store encodings, result-select code
// for memory data, and the LSU state enum. Also provides the alignment
// check used when LSU_MISALIGN_TRAP_EN is defined.
package core_pkg;

  localparam int          XLEN           = 32;
  localparam logic [1:0]  RESULT_SRC_MEM = 2'b01;

  localparam logic [2:0]  F3_B  = 3'b000;
  localparam logic [2:0]  F3_H  = 3'b001;
  localparam logic [2:0]  F3_W  = 3'b010;
  localparam logic [2:0]  F3_BU = 3'b100;
  localparam logic [2:0]  F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WAIT_GNT    = 2'd1,
    ST_WAIT_RVALID = 2'd2
  } lsu_state_e;

  // Access size comes from funct3[1:0]: 00 byte, 01 halfword, anything else
  // word (loads with 011/110/111 behave as LW).
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic bad;
    case (funct3[1:0])
      2'b00:   bad = 1'b0;
      2'b01:   bad = addr_lo[0];
      default: bad = (addr_lo != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// lsu_align: purely combinational lane logic shared by the LSU and any
// future cache. Produces store byte enables and lane-replicated store data,
// and extracts/extends a loaded byte, halfword or word. Low address bits
// that do not fit the access size are ignored (forced alignment).
module lsu_align
  import core_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      store_be,
  output logic [XLEN-1:0] store_wdata,
  output logic [XLEN-1:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store lane enables and replicated data by access size.
  always_comb begin
    store_be    = 4'b1111;
    store_wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        store_be    = 4'b0001 << addr_lo;
        store_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        store_be    = 4'b0011 << {addr_lo[1], 1'b0};
        store_wdata = {2{store_data[15:0]}};
      end
      default: begin
        store_be    = 4'b1111;
        store_wdata = store_data;
      end
    endcase
  end

  // Pick the addressed byte/halfword out of the read word.
  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'b00: byte_sel = rdata[7:0];
      2'b01: byte_sel = rdata[15:8];
      2'b10: byte_sel = rdata[23:16];
      2'b11: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Sign- or zero-extend to XLEN; unlisted encodings return the full word.
  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-access stage behind the EX/MEM register. Issues
// req/gnt/rvalid data-memory transactions, stalls upstream while one is
// outstanding, and holds the MEM/WB pipeline register.
// Optional: LSU_MISALIGN_TRAP_EN adds misaligned_o; misaligned halfword/word
// accesses then issue no request and never write the register file.
//
// Handshake: a request is transferred on a cycle where dmem_req and dmem_gnt
// are both high; request fields stay stable from first dmem_req until that
// cycle. Read data is taken on the single cycle dmem_rvalid is high while in
// WAIT_RVALID (never the grant cycle); rvalid in any other state is ignored.
module mem_stage_lsu
  import core_pkg::*;
#(
  parameter int XLEN_P = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWriteM,
  input  logic [1:0]        ResultSrcM,
  input  logic              MemWriteM,
  input  logic [2:0]        Funct3M,
  input  logic [31:0]       ALUResultM,
  input  logic [31:0]       WriteDataM,
  input  logic [4:0]        RdM,
  input  logic [31:0]       PCPlus4M,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,
  output logic              StallM,
  output logic              RegWriteW,
  output logic [1:0]        ResultSrcW,
  output logic [31:0]       ALUResultW,
  output logic [31:0]       ReadDataW,
  output logic [4:0]        RdW,
  output logic [31:0]       PCPlus4W,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic              misaligned_o,
`endif
  output lsu_state_e        lsu_state
);

  lsu_state_e state, state_next;

  logic              is_store;
  logic              is_load;
  logic              misaligned;
  logic              mem_op;
  logic              req;
  logic              stall;
  logic [3:0]        store_be;
  logic [XLEN-1:0]   store_wdata;
  logic [XLEN-1:0]   load_data;
  logic [31:0]       word_addr;
  logic [XLEN_P-1:0] alu_xlen;

  // Store wins when both store and load are flagged.
  assign is_store = MemWriteM;
  assign is_load  = (ResultSrcM == RESULT_SRC_MEM) && !MemWriteM;
  assign alu_xlen = ALUResultM[XLEN_P-1:0];

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = (is_load || is_store) && is_misaligned(Funct3M, alu_xlen[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  assign mem_op = (is_load || is_store) && !misaligned;

  lsu_align u_align (
    .funct3      (Funct3M),
    .addr_lo     (alu_xlen[1:0]),
    .store_data  (WriteDataM),
    .rdata       (dmem_rdata),
    .store_be    (store_be),
    .store_wdata (store_wdata),
    .load_data   (load_data)
  );

  // Only ADDR_W <= 32 is meaningful; upper address bits are dropped.
  assign word_addr  = {ALUResultM[31:2], 2'b00};
  assign dmem_addr  = word_addr[ADDR_W-1:0];
  assign dmem_we    = is_store;
  assign dmem_be    = is_store ? store_be : 4'b1111;
  assign dmem_wdata = store_wdata;

  // Request and stall are gated so both read 0 while reset is asserted.
  assign dmem_req  = rst_n && req;
  assign StallM    = rst_n && stall;
  assign lsu_state = state;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // FSM next state, request and stall; stall drops on the completing cycle.
  always_comb begin
    state_next = state;
    req        = 1'b0;
    stall      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_op) begin
          req = 1'b1;
          if (!dmem_gnt) begin
            stall      = 1'b1;
            state_next = ST_WAIT_GNT;
          end else if (!is_store) begin
            stall      = 1'b1;
            state_next = ST_WAIT_RVALID;
          end
        end
      end
      ST_WAIT_GNT: begin
        req   = 1'b1;
        stall = 1'b1;
        if (dmem_gnt) begin
          if (is_store) begin
            stall      = 1'b0;
            state_next = ST_IDLE;
          end else begin
            state_next = ST_WAIT_RVALID;
          end
        end
      end
      ST_WAIT_RVALID: begin
        stall = 1'b1;
        if (dmem_rvalid) begin
          stall      = 1'b0;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // MEM/WB register: advance when not stalled, else bubble RegWriteW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      ALUResultW <= 32'h0;
      ReadDataW  <= 32'h0;
      RdW        <= 5'd0;
      PCPlus4W   <= 32'h0;
    end else if (!stall) begin
      RegWriteW  <= RegWriteM && !misaligned;
      ResultSrcW <= ResultSrcM;
      ALUResultW <= ALUResultM;
      ReadDataW  <= is_load ? load_data : 32'h0;
      RdW        <= RdM;
      PCPlus4W   <= PCPlus4M;
    end else begin
      RegWriteW  <= 1'b0;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Trap flag travels with the W stage; cleared on bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      misaligned_o <= 1'b0;
    else if (!stall) misaligned_o <= misaligned;
    else             misaligned_o <= 1'b0;
  end
`endif

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-access stage directly downstream of the EX/MEM pipeline register.
- Turns M-stage control into a req/gnt/rvalid data-memory transaction and aligns load data and store data.
- Stalls upstream stages while a transaction is outstanding.
- Contains the MEM/WB pipeline register that feeds the writeback mux.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- ADDR_W, 32, width of dmem_addr.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- RegWriteM  in  1  register-file write enable of the M instruction.
- ResultSrcM  in  2  result select; 2'b01 = load.
- MemWriteM  in  1  store enable.
- Funct3M  in  3  access size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010.
- ALUResultM  in  32  effective address or ALU result.
- WriteDataM  in  32  store source register.
- RdM  in  5  destination register.
- PCPlus4M  in  32  PC+4.
- dmem_req  out  1  request valid.
- dmem_we  out  1  1 = store.
- dmem_addr  out  ADDR_W  word-aligned address {ALUResultM[31:2],2'b00}.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_gnt  in  1  request accepted.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  32  read word.
- StallM  out  1  freeze PC/IF/ID/EX/EM registers.
- RegWriteW  out  1  registered to WB.
- ResultSrcW  out  2  registered to WB.
- ALUResultW  out  32  registered to WB.
- ReadDataW  out  32  registered to WB.
- RdW  out  5  registered to WB.
- PCPlus4W  out  32  registered to WB.

Behaviour:
- Mem op in M: is_load = (ResultSrcM==2'b01); is_store = MemWriteM. If both are asserted, store wins.
- FSM states: IDLE, WAIT_GNT, WAIT_RVALID.
- IDLE with a mem op:
  - dmem_req=1 combinationally in the same cycle.
  - gnt=1 and store: complete this cycle, no stall.
  - gnt=1 and load: go to WAIT_RVALID, StallM=1.
  - gnt=0: go to WAIT_GNT, StallM=1.
- WAIT_GNT: hold req and all request fields stable (inputs are frozen by StallM). On gnt, a store returns to IDLE and a load goes to WAIT_RVALID.
- WAIT_RVALID: req=0, StallM=1. On rvalid: capture aligned data, StallM=0 in that cycle, return to IDLE.
- Minimum load latency is 2 cycles (rvalid is never same-cycle as gnt). Stores are zero-wait with immediate gnt.
- StallM is combinational: 1 whenever the M op is not completing this cycle.
- Byte enables:
  - SB: be = 4'b0001 << a[1:0], wdata = {4{WriteDataM[7:0]}}.
  - SH: be = 4'b0011 << {a[1],1'b0}, wdata = {2{WriteDataM[15:0]}}.
  - SW: be = 4'b1111, wdata = WriteDataM.
  - Loads drive be = 4'b1111, we = 0.
- Load data: select byte/halfword by a[1:0]/a[1]. Sign-extend for LB/LH, zero-extend for LBU/LHU. Funct3 011/110/111 is treated as LW.
- MEM/WB register:
  - On any cycle with StallM=0, load all W outputs from the M inputs; ReadDataW = aligned load data (0 for non-loads).
  - While StallM=1, insert a bubble: RegWriteW=0, other W fields hold.
- Reset:
  - All W outputs reset to 0, FSM to IDLE; StallM and dmem_req are 0 during reset.
  - Reset mid-transaction abandons it; a stray rvalid arriving in IDLE is ignored.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Enabled:
  - Misaligned LH/LHU/SH (a[0]=1) or LW/SW (a[1:0]!=0) raises misaligned_o (extra 1-bit output).
  - No dmem_req is issued, no stall, and RegWriteW=0 for that instruction.
  - misaligned_o is registered alongside the W stage and reset to 0.
- Disabled: port absent; offending low address bits are ignored (forced alignment per size).

Decomposition:
- Shared package core_pkg:
  - funct3 load/store encodings.
  - RESULT_SRC_MEM = 2'b01.
  - lsu_state_e enum.
- One natural sub-module, lsu_align: purely combinational be/wdata generation and load extract/extend, reused by any future cache.

Test Plan:
- SW 0xDEADBEEF @0x100, gnt same cycle -> req=1, be=1111, wdata=DEADBEEF, StallM=0 throughout.
- LB @0x103, gnt after 2 cycles, rvalid 1 cycle later with rdata=0x80FF0000 -> StallM high 4 cycles, then ReadDataW=0xFFFFFF80, RegWriteW=1.
- LHU @0x102 with rdata=0x8001xxxx -> ReadDataW=0x00008001. SH 0x1234 @0x102 -> be=1100, wdata=0x12341234.
- Load stalled in WAIT_RVALID -> RegWriteW=0 bubble each stall cycle; upstream inputs unchanged; single W write on rvalid.
- rst_n low while in WAIT_RVALID, rvalid arrives after release -> state IDLE, W outputs 0, no write.
- LSU_MISALIGN_TRAP_EN: LW @0x102 -> no req, misaligned_o=1 next cycle, RegWriteW=0.
